// File: rtl/aexm_enable_mc_if.sv
// aexm_enable_mc_if
//   Bundle of the status inputs and enable outputs of the aexm pipeline-enable
//   controller.
//   master : the core/cache side. It drives the busy, decode and control inputs
//            and receives the enables.
//   slave  : the aexm_enable_mc controller.
//   Inputs to controller : icache_busy, dcache_busy[NCH], dSTRLOD, dLOD,
//                          dSEL[SELW], dSKIP, fSTALL, timeout_clr
//   Outputs of controller: cpu_enable, cpu_mode_memop, icache_enable,
//                          dcache_enable[NCH], memop_is_load, memop_timeout
interface aexm_enable_mc_if #(
  parameter int NCH  = 2,
  parameter int SELW = 1
);
  logic            icache_busy;
  logic [NCH-1:0]  dcache_busy;
  logic            dSTRLOD;
  logic            dLOD;
  logic [SELW-1:0] dSEL;
  logic            dSKIP;
  logic            fSTALL;
  logic            timeout_clr;

  logic            cpu_enable;
  logic            cpu_mode_memop;
  logic            icache_enable;
  logic [NCH-1:0]  dcache_enable;
  logic            memop_is_load;
  logic            memop_timeout;

  modport master (
    output icache_busy, dcache_busy, dSTRLOD, dLOD, dSEL, dSKIP, fSTALL, timeout_clr,
    input  cpu_enable, cpu_mode_memop, icache_enable, dcache_enable,
           memop_is_load, memop_timeout
  );

  modport slave (
    input  icache_busy, dcache_busy, dSTRLOD, dLOD, dSEL, dSKIP, fSTALL, timeout_clr,
    output cpu_enable, cpu_mode_memop, icache_enable, dcache_enable,
           memop_is_load, memop_timeout
  );
endinterface

// File: rtl/aexm_enable_mc.sv
// aexm_enable_mc
//   Pipeline-enable and cache-issue controller for the aexm core. It arbitrates
//   one icache and NCH dcache channels and produces the global cpu_enable
//   (d_en/x_en) for every pipeline stage.
//
//   Optional feature macro: AEXM_ENABLE_TIMEOUT_EN
//     defined   : the MEM_WAIT watchdog counter, the HALT state and timeout_clr
//                 are active.
//     undefined : MEM_WAIT waits forever, memop_timeout is tied 0 and
//                 timeout_clr is ignored.
//
//   Parameters: NCH (channels, 1..4), SELW (select width, 2^SELW >= NCH),
//               TOW (watchdog width), TO_LIMIT (MEM_WAIT cycles, < 2^TOW)
//   Ports:
//     sys_clk_i  : clock, rising edge
//     sys_rst_ni : asynchronous active-low reset
//     bus        : aexm_enable_mc_if.slave (cache busy, decode info, enables)

// Per-channel slice. It decodes the latched select for one dcache channel,
// gates the issue pulse, and masks that channel's busy.
module aexm_enable_mc_lane #(
  parameter int SELW = 1,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] i_sel,
  input  logic            i_issue,
  input  logic            i_busy,
  output logic            o_en,
  output logic            o_busy
);
  logic w_hit;
  assign w_hit  = (i_sel == SELW'(IDX));
  assign o_en   = i_issue & w_hit;
  assign o_busy = i_busy & w_hit;
endmodule

module aexm_enable_mc #(
  parameter int NCH      = 2,
  parameter int SELW     = 1,
  parameter int TOW      = 8,
  parameter int TO_LIMIT = 255
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_ni,
  aexm_enable_mc_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_RUN    = 3'd1,
    S_IWAIT  = 3'd2,
    S_MISSUE = 3'd3,
    S_MWAIT  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          r_state, w_next;
  logic [SELW-1:0] r_sel;
  logic            r_load;

  logic            w_cpu_en;
  logic            w_ic_en;
  logic            w_issue;
  logic            w_memop;
  logic            w_latch;
  logic [SELW-1:0] w_sel_in;
  logic            w_busy_sel;
  logic            w_exit;
  logic [NCH-1:0]  w_dc_en;
  logic [NCH-1:0]  w_busy_hit;

  // An out-of-range select falls back to channel 0, so dcache_enable can
  // never be all-zero during MEM_ISSUE. The extra MSB keeps the compare
  // exact when NCH == 2^SELW.
  assign w_sel_in = ({1'b0, bus.dSEL} < (SELW+1)'(NCH)) ? bus.dSEL : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    aexm_enable_mc_lane #(.SELW(SELW), .IDX(g)) u_lane (
      .i_sel  (r_sel),
      .i_issue(w_issue),
      .i_busy (bus.dcache_busy[g]),
      .o_en   (w_dc_en[g]),
      .o_busy (w_busy_hit[g])
    );
  end

  // Only the selected channel's busy holds the memop. The icache must also be
  // idle, because the retiring cycle advances the whole pipeline.
  assign w_busy_sel = |w_busy_hit;
  assign w_exit     = !w_busy_sel && !bus.icache_busy;

`ifdef AEXM_ENABLE_TIMEOUT_EN
  logic [TOW-1:0] r_cnt;
  logic           r_to;
  logic           w_cnt_clr;
  logic           w_cnt_inc;
  logic           w_to_set;
  logic           w_to_clr;
  logic           w_to_hit;

  assign w_to_hit = (r_cnt == TOW'(TO_LIMIT));

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_to_set)       r_to  <= 1'b1;
      else if (w_to_clr)  r_to  <= 1'b0;
    end
  end

  assign bus.memop_timeout = r_to;
`else
  logic w_unused;
  assign w_unused          = bus.timeout_clr;
  assign bus.memop_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      r_state <= S_RST;
      r_sel   <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_sel  <= w_sel_in;
        r_load <= bus.dLOD;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_cpu_en = 1'b0;
    w_ic_en  = 1'b0;
    w_issue  = 1'b0;
    w_memop  = 1'b0;
    w_latch  = 1'b0;
`ifdef AEXM_ENABLE_TIMEOUT_EN
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_to_set  = 1'b0;
    w_to_clr  = 1'b0;
`endif
    case (r_state)
      S_RST: w_next = S_RUN;

      S_RUN: begin
        // icache first, then a live (unsquashed) memop, then the hazard stall
        if (bus.icache_busy) begin
          w_next = S_IWAIT;
        end else if (bus.dSTRLOD && !bus.dSKIP) begin
          w_next  = S_MISSUE;
          w_latch = 1'b1;
        end else begin
          w_cpu_en = !bus.fSTALL;
        end
        w_ic_en = w_cpu_en;
      end

      S_IWAIT: if (!bus.icache_busy) w_next = S_RUN;

      S_MISSUE: begin
        w_issue = 1'b1;
        w_memop = 1'b1;
        w_next  = S_MWAIT;
`ifdef AEXM_ENABLE_TIMEOUT_EN
        w_cnt_clr = 1'b1;
`endif
      end

      S_MWAIT: begin
        w_memop = 1'b1;
        if (w_exit) begin
          // retire cycle: the held instruction advances with this enable
          w_cpu_en = 1'b1;
          w_ic_en  = 1'b1;
          w_next   = S_RUN;
        end else begin
`ifdef AEXM_ENABLE_TIMEOUT_EN
          // The count reaches TO_LIMIT on the (TO_LIMIT+1)th wait cycle.
          if (w_to_hit) begin
            w_next   = S_HALT;
            w_to_set = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
`endif
        end
      end

      S_HALT: begin
`ifdef AEXM_ENABLE_TIMEOUT_EN
        if (bus.timeout_clr) begin
          w_next   = S_RUN;
          w_to_clr = 1'b1;
        end
`else
        w_next = S_RUN;
`endif
      end

      default: w_next = S_RST;
    endcase
  end

  assign bus.cpu_enable     = w_cpu_en;
  assign bus.icache_enable  = w_ic_en;
  assign bus.cpu_mode_memop = w_memop;
  assign bus.dcache_enable  = w_dc_en;
  assign bus.memop_is_load  = r_load;

endmodule
